// File: rtl/scratch_pad_port_adapter_pkg.sv
// Shared helpers for the scratch pad port adapter.
// Bit-width function and request entry field layout.
package scratch_pad_port_adapter_pkg;

  // Bits needed to represent n.
  function automatic int log2(input int n);
    int r;
    int v;
    r = 0;
    v = n;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic int req_d_lsb();
    return 0;
  endfunction

  function automatic int req_addr_lsb(input int w);
    return w;
  endfunction

  function automatic int req_wr_bit(input int aw, input int w);
    return aw + w;
  endfunction

  function automatic int req_entry_w(input int aw, input int w);
    return 1 + aw + w;
  endfunction

endpackage

// File: rtl/scratch_pad_port_adapter_sp_fifo.sv
// Synchronous FIFO with count, full and empty.
// Pointers wrap naturally; full/empty come from the count register.
module sp_fifo
  import scratch_pad_port_adapter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         d,
  output logic [WIDTH-1:0]         q,
  output logic [log2(DEPTH)-1:0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = log2(DEPTH - 1);
  localparam int CW = log2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign q       = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/scratch_pad_port_adapter.sv
// Per-port front end: in-order request queue, credit-gated read issue,
// and a response queue sized so every returned word has a slot.
module scratch_pad_port_adapter
  import scratch_pad_port_adapter_pkg::*;
#(
  parameter int PORTS          = 8,
  parameter int WIDTH          = 64,
  parameter int FRAGMENT_DEPTH = 512,
  parameter int DEPTH          = FRAGMENT_DEPTH * PORTS,
  parameter int ADDR_WIDTH     = log2(DEPTH - 1),
  parameter int REQ_DEPTH      = 4,
  parameter int RESP_DEPTH     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_rd_en,
  input  logic                  req_wr_en,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0]      req_d,
  output logic                  req_full,
  output logic [WIDTH-1:0]      resp_q,
  output logic                  resp_valid,
  input  logic                  resp_stall,
  output logic                  sp_rd_en,
  output logic                  sp_wr_en,
  output logic [ADDR_WIDTH-1:0] sp_addr,
  output logic [WIDTH-1:0]      sp_d,
  input  logic                  sp_full,
  input  logic [WIDTH-1:0]      sp_q,
  input  logic                  sp_valid,
  output logic                  sp_stall,
  output logic                  err
);

  localparam int EW  = req_entry_w(ADDR_WIDTH, WIDTH);
  localparam int WB  = req_wr_bit(ADDR_WIDTH, WIDTH);
  localparam int AL  = req_addr_lsb(WIDTH);
  localparam int DL  = req_d_lsb();
  localparam int RCW = log2(REQ_DEPTH);
  localparam int SCW = log2(RESP_DEPTH);
  localparam int OW  = log2(RESP_DEPTH) + 1;
  localparam int CRW = OW + 1;

  logic [EW-1:0]  req_entry;
  logic [EW-1:0]  head;
  logic [RCW-1:0] req_count;
  logic           req_empty;
  logic           req_push;
  logic           req_drop;

  logic [SCW-1:0] resp_count;
  logic           resp_full;
  logic           resp_empty;
  logic           resp_push;
  logic           resp_pop;

  logic [OW-1:0]  outstanding;
  logic           head_wr;
  logic           credit_ok;
  logic           fire;
  logic           rd_fire;
  logic           ret_ok;
  logic           ret_bad;
  logic           unused_req_count;

  assign req_entry = {req_wr_en, req_addr, req_d};
  assign req_push  = (req_rd_en | req_wr_en) & ~req_full;
  assign req_drop  = (req_rd_en | req_wr_en) & req_full;

  sp_fifo #(.WIDTH(EW), .DEPTH(REQ_DEPTH)) u_req (
    .clk   (clk),
    .rst   (rst),
    .push  (req_push),
    .pop   (fire),
    .d     (req_entry),
    .q     (head),
    .count (req_count),
    .full  (req_full),
    .empty (req_empty)
  );

  assign unused_req_count = ^req_count;

  assign head_wr   = head[WB];
  assign sp_addr   = head[AL +: ADDR_WIDTH];
  assign sp_d      = head[DL +: WIDTH];
  // Reads reserve a response slot; in-flight plus buffered words never exceed it.
  assign credit_ok = (CRW'(outstanding) + CRW'(resp_count)) < CRW'(RESP_DEPTH);
  assign fire      = ~req_empty & ~sp_full & (head_wr | credit_ok);
  assign sp_wr_en  = fire & head_wr;
  assign sp_rd_en  = fire & ~head_wr;
  assign rd_fire   = sp_rd_en;

  assign ret_ok    = sp_valid & (outstanding != '0);
  assign ret_bad   = sp_valid & ((outstanding == '0) | resp_full);
  assign resp_push = ret_ok & ~resp_full;
  assign resp_pop  = resp_valid & ~resp_stall;

  sp_fifo #(.WIDTH(WIDTH), .DEPTH(RESP_DEPTH)) u_resp (
    .clk   (clk),
    .rst   (rst),
    .push  (resp_push),
    .pop   (resp_pop),
    .d     (sp_q),
    .q     (resp_q),
    .count (resp_count),
    .full  (resp_full),
    .empty (resp_empty)
  );

  assign resp_valid = ~resp_empty;
  assign sp_stall   = resp_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding <= '0;
      err         <= 1'b0;
    end else begin
      unique case (1'b1)
        rd_fire & ~ret_ok: outstanding <= outstanding + OW'(1);
        ~rd_fire & ret_ok: outstanding <= outstanding - OW'(1);
        default:           outstanding <= outstanding;
      endcase
      err <= err | req_drop | ret_bad;
    end
  end

endmodule

// File: tb/tb_scratch_pad_port_adapter.sv
// Self-checking bench: directed scenarios plus randomized traffic
// against a queue-based program-order reference model.
module tb_scratch_pad_port_adapter;

  localparam int AW = 12;
  localparam int W  = 64;
  localparam int RD = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_rd_en = 1'b0;
  logic          req_wr_en = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [W-1:0]  req_d = '0;
  logic          req_full;
  logic [W-1:0]  resp_q;
  logic          resp_valid;
  logic          resp_stall = 1'b0;
  logic          sp_rd_en;
  logic          sp_wr_en;
  logic [AW-1:0] sp_addr;
  logic [W-1:0]  sp_d;
  logic          sp_full = 1'b0;
  logic [W-1:0]  sp_q;
  logic          sp_valid;
  logic          sp_stall;
  logic          err;

  always #5 clk = ~clk;

  scratch_pad_port_adapter dut (
    .clk        (clk),
    .rst        (rst),
    .req_rd_en  (req_rd_en),
    .req_wr_en  (req_wr_en),
    .req_addr   (req_addr),
    .req_d      (req_d),
    .req_full   (req_full),
    .resp_q     (resp_q),
    .resp_valid (resp_valid),
    .resp_stall (resp_stall),
    .sp_rd_en   (sp_rd_en),
    .sp_wr_en   (sp_wr_en),
    .sp_addr    (sp_addr),
    .sp_d       (sp_d),
    .sp_full    (sp_full),
    .sp_q       (sp_q),
    .sp_valid   (sp_valid),
    .sp_stall   (sp_stall),
    .err        (err)
  );

  // Scratch pad model: two-cycle read latency.
  logic [W-1:0]  spmem [int];
  logic          v1;
  logic          v2;
  logic [AW-1:0] a1;
  logic [W-1:0]  q2;
  logic          inj_v = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      v1 <= sp_rd_en;
      a1 <= sp_addr;
      v2 <= v1;
      q2 <= spmem.exists(int'(a1)) ? spmem[int'(a1)] : '0;
      if (sp_wr_en) spmem[int'(sp_addr)] = sp_d;
    end
  end

  assign sp_valid = v2 | inj_v;
  assign sp_q     = v2 ? q2 : '0;

  typedef struct {
    bit            wr;
    logic [AW-1:0] a;
    logic [W-1:0]  d;
  } req_t;

  req_t         exp_issue [$];
  logic [W-1:0] exp_resp [$];
  logic [W-1:0] ref_mem [int];
  int checks = 0;
  int failures = 0;
  int issue_cnt = 0;
  int rd_cnt = 0;
  int inflight = 0;

  task automatic chk(input string tag, input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit wr, input logic [AW-1:0] a,
                      input logic [W-1:0] d);
    int n = 0;
    while (req_full && n < 50) begin
      tick();
      n++;
    end
    chk("push_wait", req_full, 0);
    if (!req_full) begin
      req_wr_en = wr;
      req_rd_en = !wr;
      req_addr  = a;
      req_d     = d;
      exp_issue.push_back('{wr, a, d});
      if (wr) ref_mem[int'(a)] = d;
      else exp_resp.push_back(ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : '0);
      tick();
      req_wr_en = 1'b0;
      req_rd_en = 1'b0;
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_req_full"}, req_full, 0);
    chk({tag, "_resp_valid"}, resp_valid, 0);
    chk({tag, "_sp_rd_en"}, sp_rd_en, 0);
    chk({tag, "_sp_wr_en"}, sp_wr_en, 0);
    chk({tag, "_sp_stall"}, sp_stall, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  always @(negedge clk) begin
    req_t e;
    if (!rst) begin
      if (sp_wr_en | sp_rd_en) begin
        chk("issue_one_hot", sp_wr_en & sp_rd_en, 0);
        chk("issue_expected", exp_issue.size() != 0, 1);
        if (exp_issue.size() != 0) begin
          e = exp_issue.pop_front();
          chk("issue_kind", sp_wr_en, e.wr);
          chk("issue_addr", sp_addr, e.a);
          if (e.wr) chk("issue_data", sp_d, e.d);
        end
        issue_cnt++;
        if (sp_rd_en) begin
          rd_cnt++;
          inflight++;
          chk("credit_bound", inflight <= RD, 1);
        end
      end
      if (resp_valid & !resp_stall) begin
        chk("resp_expected", exp_resp.size() != 0, 1);
        if (exp_resp.size() != 0) begin
          chk("resp_data", resp_q, exp_resp.pop_front());
          inflight--;
        end
      end
      if (sp_valid) chk("sp_stall_low", sp_stall, 0);
    end
  end

  initial begin
    int n;
    int r0;
    int i0;
    rst = 1'b1;
    #2;
    chk_idle("reset");
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Write then read address 5.
    push(1'b1, AW'(5), 64'hDEAD_BEEF);
    chk("wr_latency1", sp_wr_en, 1);
    push(1'b0, AW'(5), '0);
    chk("rd_after_wr", sp_rd_en, 1);
    n = 0;
    while (!sp_valid && n < 20) begin
      tick();
      n++;
    end
    chk("sp_valid_seen", sp_valid, 1);
    tick();
    chk("resp_valid_lat1", resp_valid, 1);
    chk("resp_q_deadbeef", resp_q, 64'hDEAD_BEEF);
    repeat (3) tick();

    // Credit block with the client stalling responses.
    for (int i = 0; i < 6; i++)
      push(1'b1, AW'(20 + i), {$urandom, $urandom});
    resp_stall = 1'b1;
    r0 = rd_cnt;
    for (int i = 0; i < 6; i++)
      push(1'b0, AW'(20 + i), '0);
    repeat (15) tick();
    chk("credit_held", rd_cnt - r0, 4);
    chk("credit_resp_valid", resp_valid, 1);
    resp_stall = 1'b0;
    n = 0;
    while (exp_resp.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    chk("credit_drained", exp_resp.size(), 0);
    chk("credit_all_reads", rd_cnt - r0, 6);
    chk("credit_err", err, 0);

    // Scratch pad full: queue fills, overflow drops and flags.
    sp_full = 1'b1;
    i0 = issue_cnt;
    for (int i = 0; i < 4; i++)
      push(1'b1, AW'(30 + i), {$urandom, $urandom});
    repeat (10) tick();
    chk("full_no_issue", issue_cnt - i0, 0);
    chk("full_req_full", req_full, 1);
    req_rd_en = 1'b1;
    req_addr  = AW'(31);
    tick();
    req_rd_en = 1'b0;
    chk("overflow_err", err, 1);
    sp_full = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("consecutive_issue", sp_wr_en, 1);
      tick();
    end
    chk("issue_done", sp_wr_en, 0);

    // Reset mid-traffic drops queued requests.
    sp_full = 1'b1;
    for (int i = 0; i < 3; i++) push(1'b0, AW'(30 + i), '0);
    tick();
    rst = 1'b1;
    #1;
    chk_idle("midreset");
    exp_issue.delete();
    exp_resp.delete();
    inflight = 0;
    i0 = issue_cnt;
    tick();
    rst = 1'b0;
    sp_full = 1'b0;
    repeat (8) tick();
    chk("reset_no_issue", issue_cnt - i0, 0);
    chk("reset_no_resp", resp_valid, 0);

    // Spurious return with nothing outstanding.
    inj_v = 1'b1;
    tick();
    inj_v = 1'b0;
    chk("spurious_err", err, 1);
    chk("spurious_no_resp", resp_valid, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("err_cleared", err, 0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      sp_full    = ($urandom_range(0, 3) == 0);
      resp_stall = ($urandom_range(0, 3) == 0);
      if (!req_full && $urandom_range(0, 1) == 1)
        push(1'($urandom_range(0, 1)), AW'($urandom_range(40, 47)),
             {$urandom, $urandom});
      else
        tick();
    end
    sp_full    = 1'b0;
    resp_stall = 1'b0;
    n = 0;
    while ((exp_issue.size() != 0 || exp_resp.size() != 0) && n < 200) begin
      tick();
      n++;
    end
    chk("rand_issue_drained", exp_issue.size(), 0);
    chk("rand_resp_drained", exp_resp.size(), 0);
    chk("rand_resp_idle", resp_valid, 0);
    chk("rand_err", err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
